// File: rtl/regs_mp.sv
// Parametrised multi-port register file: registered reads, highest-index write wins on collisions.
// Optional REGS_BYPASS_EN: same-edge read of a written address returns the new data (write-first).
module regs_mp #(
    parameter int DW     = 64,
    parameter int NREG   = 32,
    parameter int AW     = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREAD-1:0]     readEn,
    input  logic [NREAD*AW-1:0]  readAddr,
    output logic [NREAD*DW-1:0]  readData,
    input  logic [NWRITE-1:0]    writeEn,
    input  logic [NWRITE*AW-1:0] writeAddr,
    input  logic [NWRITE*DW-1:0] writeData,
    output logic                 wrConflict
);

    logic [DW-1:0]       r_regs [NREG];
    logic [NREAD*DW-1:0] r_rdata;
    logic                r_conflict;

    logic [DW-1:0]       w_rd_val [NREAD];
    logic                w_conflict;

    // Value each read port captures on this edge
    always_comb begin
        for (int p = 0; p < NREAD; p++) begin
            w_rd_val[p] = r_regs[readAddr[p*AW +: AW]];
`ifdef REGS_BYPASS_EN
            // Ascending scan so the highest-index matching writer is the one forwarded
            for (int w = 0; w < NWRITE; w++) begin
                if (writeEn[w] && (writeAddr[w*AW +: AW] == readAddr[p*AW +: AW])) begin
                    w_rd_val[p] = writeData[w*DW +: DW];
                end
            end
`endif
        end
    end

    always_comb begin
        w_conflict = 1'b0;
        for (int i = 0; i < NWRITE; i++) begin
            for (int j = i + 1; j < NWRITE; j++) begin
                if (writeEn[i] && writeEn[j] &&
                    (writeAddr[i*AW +: AW] == writeAddr[j*AW +: AW])) begin
                    w_conflict = 1'b1;
                end
            end
        end
    end

    // Later nonblocking assignments override earlier ones: highest-index port wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int w = 0; w < NWRITE; w++) begin
                if (writeEn[w]) begin
                    r_regs[writeAddr[w*AW +: AW]] <= writeData[w*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata    <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int p = 0; p < NREAD; p++) begin
                if (readEn[p]) begin
                    r_rdata[p*DW +: DW] <= w_rd_val[p];
                end
            end
            r_conflict <= w_conflict;
        end
    end

    assign readData   = r_rdata;
    assign wrConflict = r_conflict;

endmodule

// File: tb/tb_regs_mp.sv
// Self-checking bench for regs_mp: directed scenarios plus randomized traffic against a queue-free array model.
// Compile with +define+REGS_BYPASS_EN to check the write-first build.
module tb_regs_mp;

    localparam int DW = 64, NREG = 32, AW = 5, NR = 2, NW = 2;
    localparam int SDW = 32, SNREG = 16, SAW = 4, SNR = 4, SNW = 1;
`ifdef REGS_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic [NR-1:0]       readEn;
    logic [NR*AW-1:0]    readAddr;
    logic [NR*DW-1:0]    readData;
    logic [NW-1:0]       writeEn;
    logic [NW*AW-1:0]    writeAddr;
    logic [NW*DW-1:0]    writeData;
    logic                wrConflict;

    logic [SNR-1:0]      s_readEn;
    logic [SNR*SAW-1:0]  s_readAddr;
    logic [SNR*SDW-1:0]  s_readData;
    logic [SNW-1:0]      s_writeEn;
    logic [SNW*SAW-1:0]  s_writeAddr;
    logic [SNW*SDW-1:0]  s_writeData;
    logic                s_wrConflict;

    regs_mp #(.DW(DW), .NREG(NREG), .AW(AW), .NREAD(NR), .NWRITE(NW)) dut (
        .clk(clk), .rst_n(rst_n),
        .readEn(readEn), .readAddr(readAddr), .readData(readData),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData),
        .wrConflict(wrConflict)
    );

    regs_mp #(.DW(SDW), .NREG(SNREG), .AW(SAW), .NREAD(SNR), .NWRITE(SNW)) dut_s (
        .clk(clk), .rst_n(rst_n),
        .readEn(s_readEn), .readAddr(s_readAddr), .readData(s_readData),
        .writeEn(s_writeEn), .writeAddr(s_writeAddr), .writeData(s_writeData),
        .wrConflict(s_wrConflict)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: register contents and what each read port should be showing
    logic [DW-1:0] mdl    [NREG];
    logic [DW-1:0] exp_rd [NR];
    logic          exp_cf;

    task automatic model_reset();
        foreach (mdl[i]) mdl[i] = '0;
        foreach (exp_rd[i]) exp_rd[i] = '0;
        exp_cf = 1'b0;
    endtask

    // Present one cycle of traffic at a falling edge, update the model, return at the next falling edge
    task automatic cycle(input logic [NW-1:0] we, input logic [NW*AW-1:0] wa,
                         input logic [NW*DW-1:0] wd, input logic [NR-1:0] re,
                         input logic [NR*AW-1:0] ra);
        logic [DW-1:0] pre [NREG];
        int            hits [NREG];
        writeEn = we; writeAddr = wa; writeData = wd;
        readEn  = re; readAddr  = ra;
        pre = mdl;
        foreach (hits[i]) hits[i] = 0;
        for (int w = 0; w < NW; w++) begin
            if (we[w]) begin
                mdl[wa[w*AW +: AW]] = wd[w*DW +: DW];
                hits[wa[w*AW +: AW]]++;
            end
        end
        exp_cf = 1'b0;
        foreach (hits[i]) if (hits[i] >= 2) exp_cf = 1'b1;
        for (int p = 0; p < NR; p++) begin
            if (re[p]) exp_rd[p] = BYP ? mdl[ra[p*AW +: AW]] : pre[ra[p*AW +: AW]];
        end
        @(posedge clk);
        @(negedge clk);
        writeEn = '0;
        readEn  = '0;
    endtask

    task automatic test_reset();
        logic [NR*DW-1:0] rd;
        checks++;
        if (readData !== '0 || wrConflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: readData=%h wrConflict=%b, required 0/0", readData, wrConflict);
        end
        cycle(2'b01, {5'd0, 5'd3}, {64'd0, 64'hDEAD}, 2'b00, '0);
        cycle(2'b00, '0, '0, 2'b01, {5'd0, 5'd3});
        rd = readData;
        checks++;
        if (rd[DW-1:0] !== 64'hDEAD) begin
            errors++;
            $display("FAIL reset_preload: got %h, required %h", rd[DW-1:0], 64'hDEAD);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (readData !== '0 || wrConflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: readData=%h wrConflict=%b, required 0/0", readData, wrConflict);
        end
        // Traffic during reset must be discarded
        writeEn = 2'b11; writeAddr = {5'd3, 5'd3}; writeData = {64'hBEEF, 64'hCAFE};
        readEn = 2'b11; readAddr = {5'd3, 5'd3};
        @(posedge clk);
        @(negedge clk);
        writeEn = '0; readEn = '0;
        model_reset();
        rst_n = 1'b1;
        cycle(2'b00, '0, '0, 2'b11, {5'd3, 5'd3});
        checks++;
        if (readData !== '0 || wrConflict !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: readData=%h wrConflict=%b, required 0/0", readData, wrConflict);
        end
    endtask

    task automatic test_latency_hold();
        cycle(2'b01, {5'd0, 5'd5}, {64'd0, 64'h1234}, 2'b00, '0);
        cycle(2'b00, '0, '0, 2'b10, {5'd5, 5'd0});
        checks++;
        if (readData[DW +: DW] !== 64'h1234) begin
            errors++;
            $display("FAIL latency_read: got %h, required %h", readData[DW +: DW], 64'h1234);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(2'b10, {5'd5, 5'd0}, {64'h9000 + 64'(i), 64'd0}, 2'b00, '0);
            checks++;
            if (readData[DW +: DW] !== 64'h1234) begin
                errors++;
                $display("FAIL hold_%0d: got %h, required %h", i, readData[DW +: DW], 64'h1234);
            end
        end
    endtask

    task automatic test_parallel_write();
        cycle(2'b11, {5'd2, 5'd1}, {64'h22, 64'h11}, 2'b00, '0);
        checks++;
        if (wrConflict !== 1'b0) begin
            errors++;
            $display("FAIL parallel_noconflict: got %b, required 0", wrConflict);
        end
        cycle(2'b00, '0, '0, 2'b11, {5'd2, 5'd1});
        checks++;
        if (readData[DW-1:0] !== 64'h11 || readData[DW +: DW] !== 64'h22) begin
            errors++;
            $display("FAIL parallel_read: got %h/%h, required 11/22", readData[DW-1:0], readData[DW +: DW]);
        end
    endtask

    task automatic test_collision();
        cycle(2'b11, {5'd7, 5'd7}, {64'hBBBB, 64'hAAAA}, 2'b00, '0);
        checks++;
        if (wrConflict !== 1'b1) begin
            errors++;
            $display("FAIL collision_flag: got %b, required 1", wrConflict);
        end
        cycle(2'b00, '0, '0, 2'b00, '0);
        checks++;
        if (wrConflict !== 1'b0) begin
            errors++;
            $display("FAIL collision_pulse: got %b, required 0", wrConflict);
        end
        cycle(2'b00, '0, '0, 2'b01, {5'd0, 5'd7});
        checks++;
        if (readData[DW-1:0] !== 64'hBBBB) begin
            errors++;
            $display("FAIL collision_winner: got %h, required %h", readData[DW-1:0], 64'hBBBB);
        end
    endtask

    task automatic test_same_edge_rw();
        logic [DW-1:0] want;
        cycle(2'b01, {5'd0, 5'd9}, {64'd0, 64'h5}, 2'b00, '0);
        cycle(2'b01, {5'd0, 5'd9}, {64'd0, 64'h6}, 2'b01, {5'd0, 5'd9});
        want = BYP ? 64'h6 : 64'h5;
        checks++;
        if (readData[DW-1:0] !== want) begin
            errors++;
            $display("FAIL same_edge_rw: got %h, required %h", readData[DW-1:0], want);
        end
        cycle(2'b00, '0, '0, 2'b01, {5'd0, 5'd9});
        checks++;
        if (readData[DW-1:0] !== 64'h6) begin
            errors++;
            $display("FAIL same_edge_next: got %h, required %h", readData[DW-1:0], 64'h6);
        end
    endtask

    task automatic test_random();
        logic [NW-1:0]    we;
        logic [NW*AW-1:0] wa;
        logic [NW*DW-1:0] wd;
        logic [NR-1:0]    re;
        logic [NR*AW-1:0] ra;
        for (int n = 0; n < 200; n++) begin
            we = NW'($urandom);
            re = NR'($urandom);
            for (int w = 0; w < NW; w++) begin
                wa[w*AW +: AW] = AW'($urandom_range(0, 7));
                wd[w*DW +: DW] = {$urandom, $urandom};
            end
            for (int p = 0; p < NR; p++) ra[p*AW +: AW] = AW'($urandom_range(0, 7));
            cycle(we, wa, wd, re, ra);
            for (int p = 0; p < NR; p++) begin
                checks++;
                if (readData[p*DW +: DW] !== exp_rd[p]) begin
                    errors++;
                    $display("FAIL rand_read n=%0d p=%0d: got %h, required %h", n, p, readData[p*DW +: DW], exp_rd[p]);
                end
            end
            checks++;
            if (wrConflict !== exp_cf) begin
                errors++;
                $display("FAIL rand_conflict n=%0d: got %b, required %b", n, wrConflict, exp_cf);
            end
        end
    endtask

    task automatic test_param_sweep();
        for (int i = 0; i < SNREG; i++) begin
            s_writeEn = 1'b1; s_writeAddr = SAW'(i); s_writeData = SDW'(i);
            @(posedge clk);
            @(negedge clk);
        end
        s_writeEn = 1'b0;
        for (int g = 0; g < SNREG / SNR; g++) begin
            s_readEn = '1;
            for (int p = 0; p < SNR; p++) s_readAddr[p*SAW +: SAW] = SAW'(SNREG - 1 - (g*SNR + p));
            @(posedge clk);
            @(negedge clk);
            s_readEn = '0;
            for (int p = 0; p < SNR; p++) begin
                checks++;
                if (s_readData[p*SDW +: SDW] !== SDW'(SNREG - 1 - (g*SNR + p))) begin
                    errors++;
                    $display("FAIL sweep_read g=%0d p=%0d: got %h, required %0d", g, p, s_readData[p*SDW +: SDW], SNREG - 1 - (g*SNR + p));
                end
            end
        end
        checks++;
        if (s_wrConflict !== 1'b0) begin
            errors++;
            $display("FAIL sweep_conflict: got %b, required 0", s_wrConflict);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        readEn = '0; readAddr = '0; writeEn = '0; writeAddr = '0; writeData = '0;
        s_readEn = '0; s_readAddr = '0; s_writeEn = '0; s_writeAddr = '0; s_writeData = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_latency_hold();
        test_parallel_write();
        test_collision();
        test_same_edge_rw();
        test_random();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
